// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
// Pure declarations: no latency, no flow control.
// Used by mem_stage_access and its RAM sub-module.
package mem_pkg;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_BYTE = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mem_state_t;

    // Reserved datatype 2'b11 falls through to the full-word case.
    function automatic logic [31:0] sext_load(input logic [31:0] data,
                                              input logic [1:0]  dt,
                                              input logic [1:0]  lane);
        logic [15:0] h;
        logic [7:0]  b;
        h = lane[1] ? data[31:16] : data[15:0];
        b = 8'(data >> {lane, 3'b000});
        case (dt)
            DT_HALF: return {{16{h[15]}}, h};
            DT_BYTE: return {{24{b[7]}}, b};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Byte-enabled 32-bit data RAM: synchronous write, asynchronous read.
// Latency: write lands at the clock edge, read is combinational.
// No backpressure; the caller decides when to write.
module data_mem_array #(
    parameter int    ADDR_BITS = 10,
    parameter string INIT_FILE = ""
) (
    input  logic                 Clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [3:0]           be,
    input  logic                 we,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage load/store unit driving a byte-enabled data RAM with sign-extended loads.
// Latency: MEM_LATENCY cycles per access; result/commit in the final (completion) cycle.
// Backpressure: Stall holds the upstream pipe for the first MEM_LATENCY-1 cycles.
module mem_stage_access
    import mem_pkg::*;
#(
    parameter int    MEM_LATENCY = 1,
    parameter int    ADDR_BITS   = 10,
    parameter string INIT_FILE   = ""
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Datatype,
    input  logic [31:0] MEM_ALUResult,
    input  logic [31:0] MEM_ReadData2,
    output logic [31:0] MEM_ReadData,
    output logic        Stall,
    output logic        AddrErr
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

    mem_state_t          state;
    logic [CW-1:0]       cnt;
    logic                req;
    logic                done;
    logic                misalign;
    logic                is_half;
    logic                is_byte;
    logic [1:0]          lane;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic [ADDR_BITS-1:0] word_idx;
    logic                unused_addr_hi;

    assign req      = MEM_MemRead | MEM_MemWrite;
    assign lane     = MEM_ALUResult[1:0];
    assign word_idx = MEM_ALUResult[ADDR_BITS+1:2];
    assign is_half  = (MEM_Datatype == DT_HALF);
    assign is_byte  = (MEM_Datatype == DT_BYTE);
    // Upper address bits alias onto the RAM.
    assign unused_addr_hi = ^MEM_ALUResult[31:ADDR_BITS+2];

    assign misalign = is_half ? lane[0] : (!is_byte && lane != 2'b00);

    // Reset wins over completion: no commit and no stall while Rst is high.
    always_comb begin
        done  = 1'b0;
        Stall = 1'b0;
        if (!Rst) begin
            if (state == ST_BUSY) begin
                if (cnt == CNT_LAST) done  = req;
                else                 Stall = 1'b1;
            end else if (req) begin
                if (MEM_LATENCY == 1) done  = 1'b1;
                else                  Stall = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && MEM_LATENCY > 1) begin
                        state <= ST_BUSY;
                        cnt   <= CW'(1);
                    end
                end
                default: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        if (is_half) begin
            be    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{MEM_ReadData2[15:0]}};
        end else if (is_byte) begin
            be    = 4'b0001 << lane;
            wdata = {4{MEM_ReadData2[7:0]}};
        end else begin
            be    = 4'b1111;
            wdata = MEM_ReadData2;
        end
    end

    data_mem_array #(
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .Clk   (Clk),
        .addr  (word_idx),
        .be    (be),
        .we    (done & MEM_MemWrite & ~misalign),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign AddrErr      = done & misalign;
    assign MEM_ReadData = (done && MEM_MemRead && !MEM_MemWrite && !misalign)
                        ? sext_load(rdata, MEM_Datatype, lane) : 32'h0;

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access at latencies 1, 3 and 4 against a byte-level memory model.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        mrd  [3];
    logic        mwr  [3];
    logic [1:0]  dt   [3];
    logic [31:0] alu  [3];
    logic [31:0] wd   [3];
    logic [31:0] rdat [3];
    logic        stall[3];
    logic        aerr [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] mm [int];

    always #5 clk = ~clk;

    mem_stage_access #(.MEM_LATENCY(1), .ADDR_BITS(10), .INIT_FILE("")) u_lat1 (
        .Clk(clk), .Rst(rst[0]), .MEM_MemRead(mrd[0]), .MEM_MemWrite(mwr[0]),
        .MEM_Datatype(dt[0]), .MEM_ALUResult(alu[0]), .MEM_ReadData2(wd[0]),
        .MEM_ReadData(rdat[0]), .Stall(stall[0]), .AddrErr(aerr[0]));

    mem_stage_access #(.MEM_LATENCY(3), .ADDR_BITS(10), .INIT_FILE("")) u_lat3 (
        .Clk(clk), .Rst(rst[1]), .MEM_MemRead(mrd[1]), .MEM_MemWrite(mwr[1]),
        .MEM_Datatype(dt[1]), .MEM_ALUResult(alu[1]), .MEM_ReadData2(wd[1]),
        .MEM_ReadData(rdat[1]), .Stall(stall[1]), .AddrErr(aerr[1]));

    mem_stage_access #(.MEM_LATENCY(4), .ADDR_BITS(10), .INIT_FILE("")) u_lat4 (
        .Clk(clk), .Rst(rst[2]), .MEM_MemRead(mrd[2]), .MEM_MemWrite(mwr[2]),
        .MEM_Datatype(dt[2]), .MEM_ALUResult(alu[2]), .MEM_ReadData2(wd[2]),
        .MEM_ReadData(rdat[2]), .Stall(stall[2]), .AddrErr(aerr[2]));

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : (u == 1) ? 3 : 4;
    endfunction

    function automatic int size_of(input logic [1:0] t);
        return (t == 2'b01) ? 2 : (t == 2'b10) ? 1 : 4;
    endfunction

    function automatic bit misal(input logic [1:0] t, input logic [31:0] a);
        int sz;
        sz = size_of(t);
        return (a % sz) != 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected load value from the byte model: little-endian gather, then sign-extend.
    function automatic logic [31:0] model_load(input int u, input logic [1:0] t, input logic [31:0] a);
        int base, sz;
        logic [31:0] v;
        base = u * 4096 + int'(a[11:0]);
        sz   = size_of(t);
        v    = 0;
        for (int i = 0; i < sz; i++)
            v = v + (32'(mm.exists(base + i) ? mm[base + i] : 8'h00) << (8 * i));
        if (sz == 2 && v >= 32'h8000) v = v + 32'hFFFF0000;
        if (sz == 1 && v >= 32'h80)   v = v + 32'hFFFFFF00;
        return v;
    endfunction

    task automatic model_store(input int u, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        int base;
        base = u * 4096 + int'(a[11:0]);
        for (int i = 0; i < size_of(t); i++) mm[base + i] = 8'(d >> (8 * i));
    endtask

    // Caller is 1ns after a rising edge; returns at the same phase with request dropped.
    task automatic access(input int u, input bit w, input bit r, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        int L;
        bit mis;
        logic [31:0] exp_rd;
        L      = lat_of(u);
        mis    = misal(t, a);
        exp_rd = (!w && !mis) ? model_load(u, t, a) : 32'h0;
        mwr[u] = w; mrd[u] = r; dt[u] = t; alu[u] = a; wd[u] = d;
        for (int c = 1; c <= L; c++) begin
            @(negedge clk);
            chk($sformatf("stall u%0d c%0d a=%h", u, c, a), 32'(stall[u]), 32'(c < L));
            chk($sformatf("addrerr u%0d c%0d a=%h", u, c, a), 32'(aerr[u]), (c == L) ? 32'(mis) : 32'h0);
            chk($sformatf("rdata u%0d c%0d a=%h t=%0d", u, c, a, t), rdat[u], (c == L) ? exp_rd : 32'h0);
            @(posedge clk); #1;
        end
        if (w && !mis) model_store(u, t, a, d);
        mwr[u] = 1'b0; mrd[u] = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("idle_stall u%0d", u), 32'(stall[u]), 32'h0);
            chk($sformatf("idle_addrerr u%0d", u), 32'(aerr[u]), 32'h0);
            chk($sformatf("idle_rdata u%0d", u), rdat[u], 32'h0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; mrd[u] = 1'b0; mwr[u] = 1'b0;
            dt[u] = 2'b00; alu[u] = 32'h0; wd[u] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset_stall u%0d", u), 32'(stall[u]), 32'h0);
            chk($sformatf("reset_addrerr u%0d", u), 32'(aerr[u]), 32'h0);
            chk($sformatf("reset_rdata u%0d", u), rdat[u], 32'h0);
        end
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;

        // Give every model byte in the exercised window a known value.
        for (int u = 0; u < 3; u++)
            for (int w = 0; w < 16; w++) access(u, 1, 0, 2'b00, 32'(w * 4), $urandom);

        // Latency-1 directed vectors.
        access(0, 1, 0, 2'b00, 32'h10, 32'hDEADBEEF);
        access(0, 0, 1, 2'b00, 32'h10, 32'h0);
        access(0, 1, 0, 2'b00, 32'h10, 32'h00000000);
        access(0, 1, 0, 2'b10, 32'h13, 32'h00000080);
        access(0, 0, 1, 2'b10, 32'h13, 32'h0);
        access(0, 0, 1, 2'b00, 32'h10, 32'h0);
        chk("model_word_after_sb", model_load(0, 2'b00, 32'h10), 32'h80000000);
        access(0, 1, 0, 2'b00, 32'h20, 32'h00000000);
        access(0, 1, 0, 2'b01, 32'h22, 32'h00001234);
        access(0, 0, 1, 2'b01, 32'h22, 32'h0);
        access(0, 0, 1, 2'b00, 32'h20, 32'h0);
        chk("model_word_after_sh", model_load(0, 2'b00, 32'h20), 32'h12340000);

        // Misaligned accesses, then aliasing through upper address bits.
        access(0, 1, 0, 2'b00, 32'h11, 32'hCAFEF00D);
        access(0, 0, 1, 2'b00, 32'h10, 32'h0);
        access(0, 0, 1, 2'b01, 32'h21, 32'h0);
        access(0, 1, 0, 2'b11, 32'h12, 32'h55555555);
        access(0, 0, 1, 2'b00, 32'hFFFFF020, 32'h0);
        idle(0, 2);

        // Latency 3: stall 1,1,0 with data only in the last cycle.
        access(1, 1, 0, 2'b00, 32'h10, 32'hA5A5_0F0F);
        access(1, 0, 1, 2'b00, 32'h10, 32'h0);
        access(1, 0, 1, 2'b01, 32'h12, 32'h0);
        idle(1, 1);

        // Latency 4: reset in cycle 2 of a store aborts it.
        mwr[2] = 1'b1; mrd[2] = 1'b0; dt[2] = 2'b00; alu[2] = 32'h30; wd[2] = 32'h13579BDF;
        @(negedge clk);
        chk("rst_abort_stall_c1", 32'(stall[2]), 32'h1);
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0; mwr[2] = 1'b0;
        @(negedge clk);
        chk("rst_abort_stall_after", 32'(stall[2]), 32'h0);
        chk("rst_abort_addrerr_after", 32'(aerr[2]), 32'h0);
        @(posedge clk); #1;
        access(2, 0, 1, 2'b00, 32'h30, 32'h0);

        // Randomized mix on all three latencies.
        for (int n = 0; n < 150; n++) begin
            for (int u = 0; u < 3; u++) begin
                bit w, r;
                logic [1:0] t;
                logic [31:0] a;
                w = 1'($urandom_range(0, 1));
                r = w ? 1'($urandom_range(0, 1)) : 1'b1;
                t = 2'($urandom_range(0, 3));
                a = $urandom & 32'hFFFF_F03F;
                access(u, w, r, t, a, $urandom);
                if ($urandom_range(0, 7) == 0) idle(u, 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
